// File: rtl/scan_clk_gen_pkg.sv
// rtl/scan_clk_gen_pkg.sv - shared state encoding and switch map for the scanner front end
package scan_clk_gen_pkg;

   // Divider/step FSM states
   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_WAIT    = 2'd1,
      S_STEP_HI = 2'd2,
      S_STEP_LO = 2'd3
   } state_t;

   // Switch bit positions
   localparam int SW_W         = 8;
   localparam int SW_RUN       = 0;
   localparam int SW_SPD_LO    = 1;
   localparam int SW_SPD_HI    = 3;
   localparam int SW_STEP_MODE = 4;
   localparam int SW_STEP      = 5;

   // Speed field width
   localparam int SPD_W = 3;

endpackage

// File: rtl/scan_clk_gen_debounce.sv
// rtl/scan_clk_gen_debounce.sv - 2-FF synchroniser plus two-sample agree debounce
module sw_debounce #(
   parameter int W          = 8,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] sw_i,
   output logic [W-1:0] sw_clean_o
);

   localparam int            CW       = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [W-1:0]  sync1_q, sync2_q;
   logic [W-1:0]  samp_q, samp_d;
   logic [W-1:0]  clean_q, clean_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sample_now;
   logic [W-1:0]  agree;

   assign sample_now = (cnt_q == CNT_LAST);
   // a bit agrees when the fresh sample matches the one taken an interval earlier
   assign agree      = ~(sync2_q ^ samp_q);

   // next-state: free-running sample counter, capture and agree-update at its terminal
   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      samp_d  = samp_q;
      clean_d = clean_q;
      if (sample_now) begin
         cnt_d   = '0;
         samp_d  = sync2_q;
         clean_d = (sync2_q & agree) | (clean_q & ~agree);
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
         samp_q  <= '0;
         clean_q <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
         samp_q  <= samp_d;
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sw_clean_o = clean_q;

endmodule

// File: rtl/scan_clk_gen.sv
// rtl/scan_clk_gen.sv - switch-selectable step clock generator with single-step mode
module scan_clk_gen
   import scan_clk_gen_pkg::*;
#(
   parameter int DIV_BASE   = 1_000_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SW_W-1:0] sw_in,
   output logic [SW_W-1:0] sw_clean,
   output logic            slowclk,
   output logic            tick
);

   localparam int             HCW   = $clog2(DIV_BASE + 1);
   localparam logic [HCW-1:0] DIV_V = HCW'(DIV_BASE);

   state_t           state_q, state_d;
   logic [HCW-1:0]   hcnt_q, hcnt_d;
   logic [SPD_W-1:0] spd_q, spd_d;
   logic             slow_q, slow_d;
   logic             tick_q, tick_d;
   logic             step_prev_q;
   logic [HCW-1:0]   half;
   logic             terminal;
   logic             step_rise;
   logic [SPD_W-1:0] sw_spd;

   sw_debounce #(
      .W          (SW_W),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .sw_i       (sw_in),
      .sw_clean_o (sw_clean)
   );

   // DIV_BASE >= 128 keeps the shifted half-period at least 1
   assign half      = DIV_V >> spd_q;
   assign terminal  = (hcnt_q == half - 1'b1);
   assign step_rise = sw_clean[SW_STEP] & ~step_prev_q;
   assign sw_spd    = sw_clean[SW_SPD_HI:SW_SPD_LO];

   // next-state: half-period counting, free-run toggling and single-step sequencing
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q + 1'b1;
      spd_d   = spd_q;
      slow_d  = slow_q;
      tick_d  = 1'b0;
      unique case (state_q)
         S_RUN: begin
            if (terminal) begin
               hcnt_d = '0;
               spd_d  = sw_spd;
               if (sw_clean[SW_STEP_MODE]) begin
                  state_d = S_WAIT;
                  slow_d  = 1'b0;
               end else begin
                  slow_d = ~slow_q;
                  tick_d = ~slow_q;
               end
            end
         end
         S_WAIT: begin
            hcnt_d = '0;
            slow_d = 1'b0;
            // leaving step mode takes priority over a simultaneous press
            if (!sw_clean[SW_STEP_MODE]) begin
               state_d = S_RUN;
            end else if (step_rise) begin
               state_d = S_STEP_HI;
               slow_d  = 1'b1;
               tick_d  = 1'b1;
               spd_d   = sw_spd;
            end
         end
         S_STEP_HI: begin
            if (terminal) begin
               hcnt_d  = '0;
               spd_d   = sw_spd;
               slow_d  = 1'b0;
               state_d = S_STEP_LO;
            end
         end
         S_STEP_LO: begin
            if (terminal) begin
               hcnt_d  = '0;
               spd_d   = sw_spd;
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d = S_RUN;
            hcnt_d  = '0;
         end
      endcase
   end

   // state registers; reset overrides any pulse in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_RUN;
         hcnt_q      <= '0;
         spd_q       <= '0;
         slow_q      <= 1'b0;
         tick_q      <= 1'b0;
         step_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         spd_q       <= spd_d;
         slow_q      <= slow_d;
         tick_q      <= tick_d;
         step_prev_q <= sw_clean[SW_STEP];
      end
   end

   assign slowclk = slow_q;
   assign tick    = tick_q;

endmodule

// File: doc/scan_clk_gen.md
# scan_clk_gen

Front-end stage for the Larson scanner: runs on the board clock and produces the two inputs the scanner consumes, the scanner step clock `slowclk` and the cleaned switch vector `sw_clean`, which drives the scanner's `sw_in`. The block synchronises and debounces the raw switches and divides `clk` to a switch-selectable step rate. It also provides a single-step mode that emits exactly one `slowclk` period per press of a step switch.

## Interface
- `DIV_BASE`, default 1_000_000: `slowclk` half-period in `clk` cycles at speed 0. Must be ≥ 128.
- `DEB_CYCLES`, default 1_000_000: debounce sample interval in `clk` cycles. Must be ≥ 2.
- `clk`  in  1  board clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sw_in`  in  8  raw asynchronous switches.
- `sw_clean`  out  8  synchronised, debounced switches; feeds the scanner's `sw_in`.
- `slowclk`  out  1  registered scanner step clock.
- `tick`  out  1  one-cycle pulse, high in the cycle `slowclk` goes 0→1.

## Operation
- Switch map:
  - bit0: run/hold, passed through only.
  - bits 3:1: speed `spd`.
  - bit4: step mode.
  - bit5: step button.
  - bits 7:6: passed through only.
- Reset: the following all clear to 0 in the cycle after `rst_n` is sampled low, and `rst_n` overrides everything, including a reset mid-pulse.
  - Outputs: `sw_clean`, `slowclk`, `tick`.
  - Internal: sync FFs, sample registers, debounce counter, `hcnt`, `spd_q`, step-edge register.
  - FSM returns to S_RUN.
- Synchroniser: a 2-FF chain per bit.
- Debounce:
  - A shared counter counts 0..DEB_CYCLES-1. At the terminal value, each bit's synced value is captured into `samp`.
  - `sw_clean[i]` takes the new sample only if it equals the previous `samp[i]`.
  - Pulses shorter than DEB_CYCLES never propagate.
- Half-period: `HALF = DIV_BASE >> spd_q`, always ≥ 1. `spd_q` loads `sw_clean[3:1]` at every half-period terminal and on entry to S_STEP_HI. A speed change therefore never shortens a half-period already in progress.
- `hcnt` counts 0..HALF-1. A terminal cycle is `hcnt == HALF-1`, after which `hcnt` returns to 0.
- FSM states:
  - S_RUN: `slowclk` toggles at each terminal. At a terminal with `sw_clean[4]=1`, the FSM moves to S_WAIT and forces `slowclk` to 0. If `slowclk` was 1 it falls; if it was 0 no rise occurs.
  - S_WAIT: `slowclk` is 0 and `hcnt` is held at 0.
    - A rising edge of `sw_clean[5]` moves to S_STEP_HI. The edge is detected against a registered previous value.
    - If `sw_clean[4]=0`, the FSM moves to S_RUN; the first rise follows HALF cycles later.
    - If both happen in the same cycle, the mode exit wins.
  - S_STEP_HI: `slowclk` is 1 for HALF cycles, then S_STEP_LO.
  - S_STEP_LO: `slowclk` is 0 for HALF cycles, then S_WAIT. `sw_clean[4]=0` still completes this low phase first.
  - Step edges during S_STEP_HI or S_STEP_LO are ignored, not queued.

## Timing
- `sw_in` to `sw_clean` latency:
  - Minimum is 2 sync cycles plus the wait to the next sample, plus one more sample interval.
  - Worst case is 2·DEB_CYCLES + 3 cycles.
  - A change held stable for at least 2·DEB_CYCLES + 3 cycles always propagates.
- `slowclk` and `tick` are registered. `tick` coincides with the cycle `slowclk` is first 1, in both S_RUN and S_STEP_HI.
- Run-mode period is 2·HALF cycles at a 50% duty cycle, with exactly one `tick` per period.
- Step pulse:
  - `slowclk` rises 1 cycle after the `sw_clean[5]` rising edge is registered.
  - It stays high HALF cycles and then low at least HALF cycles.
- After `rst_n` deasserts, the first `slowclk` rise occurs HALF(spd=0) = DIV_BASE cycles later, provided `sw_clean[4]` is still 0.

## Structure
- Shared package holds:
  - State encoding S_RUN/S_WAIT/S_STEP_HI/S_STEP_LO (2 bits).
  - Switch index constants SW_RUN=0, SW_SPD_LO=1, SW_SPD_HI=3, SW_STEP_MODE=4, SW_STEP=5.
  - Speed width constant 3.
- One sub-module, `sw_debounce`, contains the synchroniser, sample counter and per-bit agree logic, parameterised by width and DEB_CYCLES. The divider and FSM stay in the top module.

## Test plan
Bench parameters: DIV_BASE=128, DEB_CYCLES=4.
- Reset: `rst_n`=0 for 3 cycles with `sw_in`=8'hFF → `sw_clean`=0, `slowclk`=0, `tick`=0 throughout; first `slowclk` rise 128 cycles after release if bit4 has not settled high.
- Debounce: `sw_in`=8'h01 held → `sw_clean`=8'h01 within 11 cycles. A 1-cycle and a 3-cycle pulse on bit6 → `sw_clean[6]` stays 0.
- Run rates:
  - `sw_clean[3:1]`=0 → `slowclk` period 256 cycles, one `tick` per rise.
  - `sw_clean[3:1]`=7 → period 2 cycles.
- Speed change 10 cycles into a 128-cycle half at speed 0, switching to speed 1 → that half still lasts 128 cycles; subsequent halves last 64.
- Step mode: bit4=1, then bit5 0→1 → exactly one `slowclk` pulse, 128 cycles high, one `tick`. A second bit5 edge during the pulse → no extra pulse. Clearing bit4 in S_WAIT → free-run resumes after 128 cycles.
- Reset mid-S_STEP_HI → `slowclk`=0 the next cycle; after release, operation is identical to the post-reset case.
